// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, talks to the icache, and queues {pc, inst} pairs toward ID.
// Optional IF_PERF_CNT_EN macro adds fetched-instruction and icache-wait-cycle counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ic_pc_o,
    output logic        ic_fetch_en_o,
    input  logic [31:0] ic_inst_i,
    input  logic        ic_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_icwait_o
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_REDIR_WAIT = 1'b1
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               fetch_en_q, fetch_en_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    fetch_entry_t       fifo_q [FIFO_DEPTH];
    fetch_entry_t       fifo_d [FIFO_DEPTH];
`ifdef IF_PERF_CNT_EN
    logic [31:0]        perf_fetched_q, perf_fetched_d;
    logic [31:0]        perf_icwait_q, perf_icwait_d;
`endif

    logic               fifo_full;
    logic               push;
    logic               pop;
    logic [31:0]        redirect_tgt;
    fetch_entry_t       head;

    // Full test uses the registered count only, so id_ready_i never reaches the PC path.
    assign fifo_full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop          = (count_q != '0) && id_ready_i;
    assign redirect_tgt = redirect_pc_i & ~32'h0000_0003;

    // Next-state: the PC only moves on a cycle where the icache returns data.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_en_d    = 1'b1;
        redirect_pc_d = redirect_pc_q;
        push          = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (redirect_i) begin
                    if (ic_ready_i) begin
                        pc_d = redirect_tgt;
                    end else begin
                        redirect_pc_d = redirect_tgt;
                        state_d       = ST_REDIR_WAIT;
                    end
                end else if (ic_ready_i && !fifo_full) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            ST_REDIR_WAIT: begin
                if (redirect_i) begin
                    redirect_pc_d = redirect_tgt;
                    if (ic_ready_i) begin
                        pc_d    = redirect_tgt;
                        state_d = ST_RUN;
                    end
                end else if (ic_ready_i) begin
                    pc_d    = redirect_pc_q;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FIFO bookkeeping; any redirect empties the queue regardless of push/pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end

        if (redirect_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q].pc   = pc_q;
                fifo_d[wr_ptr_q].inst = ic_inst_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(push);
        perf_icwait_d  = perf_icwait_q + 32'(fetch_en_q && !ic_ready_i);
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            fetch_en_q    <= 1'b0;
            redirect_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef IF_PERF_CNT_EN
            perf_fetched_q <= '0;
            perf_icwait_q  <= '0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_en_q    <= fetch_en_d;
            redirect_pc_q <= redirect_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
`ifdef IF_PERF_CNT_EN
            perf_fetched_q <= perf_fetched_d;
            perf_icwait_q  <= perf_icwait_d;
`endif
        end
    end

    // Outputs come straight from flops; head fields read as zero while empty.
    assign head          = fifo_q[rd_ptr_q];
    assign ic_pc_o       = pc_q;
    assign ic_fetch_en_o = fetch_en_q;
    assign id_valid_o    = (count_q != '0);
    assign id_pc_o       = id_valid_o ? head.pc   : 32'd0;
    assign id_inst_o     = id_valid_o ? head.inst : 32'd0;
`ifdef IF_PERF_CNT_EN
    assign perf_fetched_o = perf_fetched_q;
    assign perf_icwait_o  = perf_icwait_q;
`endif

endmodule
